// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: unified instruction/data memory handshake between the control
// sequencer (master) and the memory port (slave).
//   mem_req   master->slave  request, held until mem_ready
//   mem_we    master->slave  write qualifier for mem_req
//   mem_ready slave->master  memory completes the current request this cycle
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control sequencer.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// every datapath strobe. Outputs are combinational from the state register
// plus the current decoder fields, ALU flags and mem_ready.
//   clk, rst          clock; synchronous active-high reset
//   opcode/funct3/funct7  decoder fields (valid from DECODE onward, IR is stable)
//   zero, lt, ltu     ALU comparison flags for branch resolution
//   mem               memory handshake (mc_ctrl_if.master)
//   ir_we             load IR from memory read data
//   pc_we, pc_sel     PC commit and source select (0 pc+4, 1 pc+imm, 2 ALU&~1)
//   alu_a_sel, alu_b_sel, alu_op  ALU operand/op selects
//   rf_we, wb_sel     register-file write enable and source (0 ALU, 1 mem, 2 pc+4)
//   state             current sequencer state
//   illegal           sticky flag for an unsupported encoding
module mc_ctrl (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            zero,
  input  logic            lt,
  input  logic            ltu,
  mc_ctrl_if.master       mem,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic [3:0]      alu_op,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [2:0]      state,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASSB = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  state_t  state_q, state_n;
  logic    illegal_q;

  // Instruction class, decoded straight from the IR fields. IR only changes
  // on ir_we in FETCH, so these stay valid through EXEC, MEM and WB.
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, is_jalr;
  logic legal;
  logic br_taken, br_bad;

  always_comb begin
    is_r    = (opcode == OPC_R);
    is_i    = (opcode == OPC_I);
    is_ld   = (opcode == OPC_LOAD);
    is_st   = (opcode == OPC_STORE);
    is_br   = (opcode == OPC_BRANCH);
    is_lui  = (opcode == OPC_LUI);
    is_jal  = (opcode == OPC_JAL);
    is_jalr = (opcode == OPC_JALR);

    legal = is_r | is_i | is_ld | is_st | is_br | is_lui | is_jal | is_jalr;
    if (is_r) begin
      if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000))
        legal = 1'b0;
      else if ((funct7 == 7'b0100000) && (funct3 != 3'b000) && (funct3 != 3'b101))
        legal = 1'b0;
    end
  end

  // Branch condition; funct3 010/011 are reserved and trap in EXEC.
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  function automatic alu_op_t alu_fn(input logic [2:0] f3, input logic alt);
    alu_op_t r;
    case (f3)
      3'b000:  r = alt ? OP_SUB : OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = alt ? OP_SRA : OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  logic    req_c, we_c, ir_we_c, pc_we_c, a_sel_c, b_sel_c, rf_we_c;
  logic [1:0] pc_sel_c, wb_sel_c;
  alu_op_t op_c;

  always_comb begin
    state_n  = state_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    pc_sel_c = PC_PLUS4;
    a_sel_c  = 1'b0;
    b_sel_c  = 1'b0;
    op_c     = OP_ADD;
    rf_we_c  = 1'b0;
    wb_sel_c = WB_ALU;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_we_c = 1'b1;
          state_n = S_DECODE;
        end
      end

      S_DECODE: state_n = legal ? S_EXEC : S_TRAP;

      S_EXEC: begin
        if (is_r) begin
          op_c    = alu_fn(funct3, funct7[5]);
          state_n = S_WB;
        end else if (is_i) begin
          // Only the shift-right immediate uses funct7[5]; elsewhere those
          // bits are immediate data.
          b_sel_c = 1'b1;
          op_c    = alu_fn(funct3, funct7[5] & (funct3 == 3'b101));
          state_n = S_WB;
        end else if (is_lui) begin
          b_sel_c = 1'b1;
          op_c    = OP_PASSB;
          state_n = S_WB;
        end else if (is_ld || is_st) begin
          b_sel_c = 1'b1;
          state_n = S_MEM;
        end else if (is_br) begin
          op_c = OP_SUB;
          if (br_bad) begin
            state_n = S_TRAP;
          end else begin
            pc_we_c  = 1'b1;
            pc_sel_c = br_taken ? PC_IMM : PC_PLUS4;
            state_n  = S_FETCH;
          end
        end else if (is_jal) begin
          rf_we_c  = 1'b1;
          wb_sel_c = WB_PC4;
          pc_we_c  = 1'b1;
          pc_sel_c = PC_IMM;
          state_n  = S_FETCH;
        end else if (is_jalr) begin
          b_sel_c  = 1'b1;
          rf_we_c  = 1'b1;
          wb_sel_c = WB_PC4;
          pc_we_c  = 1'b1;
          pc_sel_c = PC_ALU;
          state_n  = S_FETCH;
        end else begin
          state_n = S_TRAP;
        end
      end

      S_MEM: begin
        // Address operands stay selected for the whole access.
        req_c   = 1'b1;
        we_c    = is_st;
        b_sel_c = 1'b1;
        if (mem.mem_ready) begin
          if (is_st) begin
            pc_we_c = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we_c  = 1'b1;
        wb_sel_c = is_ld ? WB_MEM : WB_ALU;
        pc_we_c  = 1'b1;
        state_n  = S_FETCH;
      end

      S_TRAP: state_n = S_TRAP;

      default: state_n = S_TRAP;
    endcase

    // Reset abandons any access in flight: no request, no IR load, no commit.
    if (rst) begin
      req_c    = 1'b0;
      we_c     = 1'b0;
      ir_we_c  = 1'b0;
      pc_we_c  = 1'b0;
      pc_sel_c = PC_PLUS4;
      a_sel_c  = 1'b0;
      b_sel_c  = 1'b0;
      op_c     = OP_ADD;
      rf_we_c  = 1'b0;
      wb_sel_c = WB_ALU;
    end
  end

  assign mem.mem_req = req_c;
  assign mem.mem_we  = we_c;
  assign ir_we       = ir_we_c;
  assign pc_we       = pc_we_c;
  assign pc_sel      = pc_sel_c;
  assign alu_a_sel   = a_sel_c;
  assign alu_b_sel   = b_sel_c;
  assign alu_op      = op_c;
  assign rf_we       = rf_we_c;
  assign wb_sel      = wb_sel_c;
  assign state       = state_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Table of single-instruction
// EXEC checks, hand-written multi-cycle sequences, and randomized instruction
// streams checked against a per-instruction expected-cycle script.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] state;

  mc_ctrl_if mif ();

  mc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .mem       (mif),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .state     (state),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [31:0] w;
    logic        z, l, lu;
    outs_t       e;
  } vec_t;

  typedef struct {
    logic  r;
    logic  rdy;
    outs_t e;
  } step_t;

  int n_cmp = 0;
  int n_bad = 0;
  step_t script[$];

  function automatic outs_t idle(input logic [2:0] st, input logic ill);
    outs_t o = '0;
    o.state   = st;
    o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t ex(input logic pcw, input logic [1:0] pcs, input logic bs,
                               input logic [3:0] op, input logic rfw, input logic [1:0] wbs);
    outs_t o = idle(3'd2, 1'b0);
    o.pc_we = pcw; o.pc_sel = pcs; o.alu_b_sel = bs;
    o.alu_op = op; o.rf_we = rfw; o.wb_sel = wbs;
    return o;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o.state = state; o.mem_req = mif.mem_req; o.mem_we = mif.mem_we;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_sel = pc_sel;
    o.alu_a_sel = alu_a_sel; o.alu_b_sel = alu_b_sel; o.alu_op = alu_op;
    o.rf_we = rf_we; o.wb_sel = wb_sel; o.illegal = illegal;
    return o;
  endfunction

  task automatic chk(input string nm, input outs_t a, input outs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %p expected %p", nm, a, e);
    end
  endtask

  task automatic chkv(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic tick(input logic r, input logic rdy);
    rst = r; mif.mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic step(input logic r, input logic rdy, input outs_t e, input string nm);
    rst = r; mif.mem_ready = rdy;
    #1;
    chk(nm, cur(), e);
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [31:0] w);
    opcode = w[6:0];
    funct3 = w[14:12];
    funct7 = w[31:25];
  endtask

  // Reference ALU code: funct3 indexes the base operation; the alternate
  // bit turns ADD into SUB and SRL into SRA.
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return base[f3];
  endfunction

  task automatic push(input logic r, input logic rdy, input outs_t e);
    step_t s;
    s.r = r; s.rdy = rdy; s.e = e;
    script.push_back(s);
  endtask

  // Builds the expected cycle-by-cycle script for one instruction given
  // fetch wait cycles fw and memory wait cycles mw. A trapped instruction
  // ends with three TRAP cycles and a reset cycle.
  task automatic build(input logic [31:0] w, input logic fz, input logic fl, input logic flu,
                       input int fw, input int mw);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit r_ = (op == 7'h33), i_ = (op == 7'h13), ld = (op == 7'h03), st = (op == 7'h23);
    bit br = (op == 7'h63), lui = (op == 7'h37), jal = (op == 7'h6F), jalr = (op == 7'h67);
    bit ok = r_ | i_ | ld | st | br | lui | jal | jalr;
    bit trap = 0, to_wb = 0, to_mem = 0;
    outs_t e;
    if (r_ && !(f7 == 7'd0 || f7 == 7'd32)) ok = 0;
    if (r_ && f7 == 7'd32 && !(f3 == 3'd0 || f3 == 3'd5)) ok = 0;

    for (int i = 0; i <= fw; i++) begin
      e = idle(3'd0, 1'b0); e.mem_req = 1;
      e.ir_we = (i == fw);
      push(0, (i == fw), e);
    end
    push(0, 1'($urandom_range(0, 1)), idle(3'd1, 1'b0));

    if (!ok) trap = 1;
    else begin
      e = idle(3'd2, 1'b0);
      if (r_)  begin e.alu_op = alu_code(f3, f7[5]); to_wb = 1; end
      if (i_)  begin e.alu_b_sel = 1; e.alu_op = alu_code(f3, f7[5] && f3 == 3'd5); to_wb = 1; end
      if (lui) begin e.alu_b_sel = 1; e.alu_op = 4'd10; to_wb = 1; end
      if (ld || st) begin e.alu_b_sel = 1; to_mem = 1; end
      if (br) begin
        bit t;
        e.alu_op = 4'd1;
        case (f3)
          3'd0: t = fz;   3'd1: t = !fz;
          3'd4: t = fl;   3'd5: t = !fl;
          3'd6: t = flu;  3'd7: t = !flu;
          default: begin t = 0; trap = 1; end
        endcase
        if (!trap) begin e.pc_we = 1; e.pc_sel = t ? 2'd1 : 2'd0; end
      end
      if (jal)  begin e.rf_we = 1; e.wb_sel = 2; e.pc_we = 1; e.pc_sel = 1; end
      if (jalr) begin e.alu_b_sel = 1; e.rf_we = 1; e.wb_sel = 2; e.pc_we = 1; e.pc_sel = 2; end
      push(0, 1'($urandom_range(0, 1)), e);
      if (to_mem) begin
        for (int i = 0; i <= mw; i++) begin
          e = idle(3'd3, 1'b0); e.mem_req = 1; e.mem_we = st; e.alu_b_sel = 1;
          e.pc_we = st && (i == mw);
          push(0, (i == mw), e);
        end
        if (ld) to_wb = 1;
      end
      if (to_wb) begin
        e = idle(3'd4, 1'b0); e.rf_we = 1; e.wb_sel = ld ? 2'd1 : 2'd0; e.pc_we = 1;
        push(0, 1'($urandom_range(0, 1)), e);
      end
    end

    if (trap) begin
      for (int i = 0; i < 3; i++) push(0, 1'($urandom_range(0, 1)), idle(3'd7, 1'b1));
      push(1, 1'($urandom_range(0, 1)), idle(3'd7, 1'b1));
    end
  endtask

  vec_t tbl[22];

  initial begin
    int st_lw[8] = '{0, 0, 0, 1, 2, 3, 3, 4};
    logic rd_lw[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int st_add[4] = '{0, 1, 2, 4};
    logic [6:0] ops[8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
    outs_t e;

    tbl[0]  = '{32'h002081B3, 0, 0, 0, ex(0, 0, 0, 4'd0, 0, 0)};   // ADD
    tbl[1]  = '{32'h402081B3, 0, 0, 0, ex(0, 0, 0, 4'd1, 0, 0)};   // SUB
    tbl[2]  = '{32'h4020D1B3, 0, 0, 0, ex(0, 0, 0, 4'd7, 0, 0)};   // SRA
    tbl[3]  = '{32'h0020B1B3, 0, 0, 0, ex(0, 0, 0, 4'd4, 0, 0)};   // SLTU
    tbl[4]  = '{32'h00500093, 0, 0, 0, ex(0, 0, 1, 4'd0, 0, 0)};   // ADDI
    tbl[5]  = '{32'h4030D093, 0, 0, 0, ex(0, 0, 1, 4'd7, 0, 0)};   // SRAI
    tbl[6]  = '{32'h4000C093, 0, 0, 0, ex(0, 0, 1, 4'd5, 0, 0)};   // XORI, imm bit30 set
    tbl[7]  = '{32'h123450B7, 0, 0, 0, ex(0, 0, 1, 4'd10, 0, 0)};  // LUI
    tbl[8]  = '{32'h00012083, 0, 0, 0, ex(0, 0, 1, 4'd0, 0, 0)};   // LW
    tbl[9]  = '{32'h00112023, 0, 0, 0, ex(0, 0, 1, 4'd0, 0, 0)};   // SW
    tbl[10] = '{32'h00209463, 1, 0, 0, ex(1, 0, 0, 4'd1, 0, 0)};   // BNE not taken
    tbl[11] = '{32'h00209463, 0, 0, 0, ex(1, 1, 0, 4'd1, 0, 0)};   // BNE taken
    tbl[12] = '{32'h0020C463, 0, 1, 0, ex(1, 1, 0, 4'd1, 0, 0)};   // BLT taken
    tbl[13] = '{32'h0020F463, 0, 0, 1, ex(1, 0, 0, 4'd1, 0, 0)};   // BGEU not taken
    tbl[14] = '{32'h0020D463, 0, 0, 0, ex(1, 1, 0, 4'd1, 0, 0)};   // BGE taken
    tbl[15] = '{32'h0020A463, 0, 0, 0, ex(0, 0, 0, 4'd1, 0, 0)};   // reserved branch
    tbl[16] = '{32'h008000EF, 0, 0, 0, ex(1, 1, 0, 4'd0, 1, 2)};   // JAL
    tbl[17] = '{32'h000080E7, 0, 0, 0, ex(1, 2, 1, 4'd0, 1, 2)};   // JALR
    tbl[18] = '{32'h0000007F, 0, 0, 0, idle(3'd7, 1'b1)};          // bad opcode
    tbl[19] = '{32'h402091B3, 0, 0, 0, idle(3'd7, 1'b1)};          // SUB-form funct3=001
    tbl[20] = '{32'h022081B3, 0, 0, 0, idle(3'd7, 1'b1)};          // funct7=0000001
    tbl[21] = '{32'h00109093, 0, 0, 0, ex(0, 0, 1, 4'd2, 0, 0)};   // SLLI

    mif.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset holds every strobe low even with mem_ready asserted.
    step(1, 1, idle(3'd0, 1'b0), "reset_hold");

    // Table: third cycle of each instruction (EXEC, or TRAP after DECODE).
    foreach (tbl[i]) begin
      tick(1, 0);
      set_instr(tbl[i].w);
      zero = tbl[i].z; lt = tbl[i].l; ltu = tbl[i].lu;
      e = idle(3'd0, 1'b0); e.mem_req = 1; e.ir_we = 1;
      step(0, 1, e, $sformatf("tbl%0d_fetch", i));
      step(0, 0, idle(3'd1, 1'b0), $sformatf("tbl%0d_decode", i));
      step(0, 0, tbl[i].e, $sformatf("tbl%0d_exec", i));
    end

    // ADD with zero-wait memory: FETCH, DECODE, EXEC, WB, back to FETCH.
    tick(1, 0);
    set_instr(32'h002081B3);
    for (int i = 0; i < 4; i++) begin
      rst = 0; mif.mem_ready = 1; #1;
      chkv($sformatf("add_state%0d", i), state, st_add[i]);
      if (i == 2) begin
        chkv("add_exec_op", alu_op, 0);
        chkv("add_exec_bsel", alu_b_sel, 0);
      end
      if (i == 3) begin
        chkv("add_wb_rfwe", rf_we, 1);
        chkv("add_wb_sel", wb_sel, 0);
        chkv("add_wb_pcwe", pc_we, 1);
      end
      @(posedge clk); #1;
    end
    chkv("add_done", state, 0);

    // LW: 2 fetch waits, 1 memory wait, 8 cycles total.
    set_instr(32'h00012083);
    for (int i = 0; i < 8; i++) begin
      rst = 0; mif.mem_ready = rd_lw[i]; #1;
      chkv($sformatf("lw_state%0d", i), state, st_lw[i]);
      if (i < 3) chkv($sformatf("lw_req%0d", i), mif.mem_req, 1);
      if (i == 5 || i == 6) begin
        chkv($sformatf("lw_memreq%0d", i), mif.mem_req, 1);
        chkv($sformatf("lw_memwe%0d", i), mif.mem_we, 0);
      end
      if (i == 7) chkv("lw_wbsel", wb_sel, 1);
      @(posedge clk); #1;
    end
    chkv("lw_total", state, 0);

    // Reset during a stalled store: request abandoned, no commit.
    set_instr(32'h00112023);
    e = idle(3'd0, 1'b0); e.mem_req = 1; e.ir_we = 1;
    step(0, 1, e, "sw_fetch");
    step(0, 0, idle(3'd1, 1'b0), "sw_decode");
    step(0, 0, ex(0, 0, 1, 4'd0, 0, 0), "sw_exec");
    e = idle(3'd3, 1'b0); e.mem_req = 1; e.mem_we = 1; e.alu_b_sel = 1;
    step(0, 0, e, "sw_mem_wait");
    step(1, 1, idle(3'd3, 1'b0), "sw_rst");
    e = idle(3'd0, 1'b0); e.mem_req = 1;
    step(0, 0, e, "sw_after_rst");

    // Randomized instruction stream.
    tick(1, 0);
    for (int n = 0; n < 250; n++) begin
      logic [31:0] w;
      int k = $urandom_range(0, 9);
      logic fz, fl, flu;
      w = $urandom;
      if (k < 8) w[6:0] = ops[k];
      else if (k == 8) w[6:0] = 7'($urandom);
      case ($urandom_range(0, 3))
        0, 1: w[31:25] = 7'd0;
        2:    w[31:25] = 7'd32;
        default: ;
      endcase
      fz = 1'($urandom); fl = 1'($urandom); flu = 1'($urandom);
      set_instr(w);
      zero = fz; lt = fl; ltu = flu;
      script.delete();
      build(w, fz, fl, flu, $urandom_range(0, 2), $urandom_range(0, 2));
      foreach (script[j])
        step(script[j].r, script[j].rdy, script[j].e, $sformatf("rnd%0d_c%0d_w%08h", n, j, w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the RV32I datapath. It consumes the field outputs of the instruction decoder (opcode, funct3, funct7) plus ALU comparison flags, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives every datapath strobe: IR load, PC update and select, ALU operand and op select, memory request, and register-file write-back. It sits between the unified instruction/data memory port and the IR → decoder → regfile/ALU path.

## Interface
Parameters: none.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- opcode  in  7  decoder opcode field
- funct3  in  3  decoder funct3 field
- funct7  in  7  decoder funct7 field
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  commit PC
- pc_sel  out  2  0: pc+4; 1: pc+imm32; 2: ALU result with bit0 cleared
- alu_a_sel  out  1  0: rs1; 1: pc
- alu_b_sel  out  1  0: rs2; 1: imm32
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0: ALU; 1: memory data; 2: pc+4
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
- illegal  out  1  sticky; set on an unsupported encoding

## Operation
- Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 0110111 (LUI), 1101111 (JAL), 1100111 (JALR).
- PC stays unchanged for the whole instruction. It commits with exactly one pc_we pulse in the instruction's final cycle.
- FETCH: mem_req=1, mem_we=0. In the cycle mem_ready=1: ir_we=1 and go to DECODE; otherwise hold.
- DECODE: one cycle. IR is stable, so the decoder fields are valid.
  - Unsupported opcode → TRAP.
  - R-type with funct7 ∉ {0000000, 0100000} → TRAP.
  - R-type with funct7=0100000 and funct3 ∉ {000, 101} → TRAP.
  - Otherwise → EXEC.
- EXEC, by instruction class:
  - R: alu_b_sel=0; alu_op from funct3, with funct7[5] selecting SUB/SRA. → WB.
  - I-ALU: alu_b_sel=1; funct7[5] is used only when funct3=101 (SRA). → WB.
  - LUI: alu_b_sel=1, alu_op=PASSB. → WB.
  - LOAD/STORE: alu_b_sel=1, alu_op=ADD (address). → MEM.
  - BRANCH: alu_op=SUB, pc_we=1, pc_sel=taken?1:0. → FETCH.
    - taken by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
    - funct3 010/011 → TRAP, with no pc_we.
  - JAL: rf_we=1, wb_sel=2, pc_we=1, pc_sel=1. → FETCH.
  - JALR: alu_a_sel=0, alu_b_sel=1, alu_op=ADD, rf_we=1, wb_sel=2, pc_we=1, pc_sel=2. → FETCH.
- MEM: mem_req=1, mem_we=STORE. Hold ALU address controls. On mem_ready:
  - STORE: pc_we=1, pc_sel=0, → FETCH.
  - LOAD: → WB.
- WB: rf_we=1, wb_sel = LOAD?1:0, pc_we=1, pc_sel=0. → FETCH.
- TRAP: all strobes 0, illegal=1. Stays in TRAP until rst.
- Defaults in every state unless stated above: all strobes 0, selects 0, alu_op=ADD.
- rd=x0 suppression is the regfile's job; this block asserts rf_we regardless of rd.

## Timing
- Outputs are combinational from the state register plus current inputs. ir_we and the MEM-exit pc_we are qualified by mem_ready the same cycle.
- Reset: in any state, rst=1 at an edge → FETCH, illegal=0. While rst=1, all strobes are forced to 0, including mem_req.
- Reset mid-access abandons the request; no ir_we or pc_we is issued.
- mem_ready is ignored when mem_req=0.
- mem_req never deasserts before mem_ready. Back-to-back requests are legal (MEM→WB→FETCH reissues after one idle cycle).
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - ALU/LUI: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH/JAL/JALR: 3 cycles
  - Each memory wait cycle adds 1 cycle.
- Exactly one pc_we per retired instruction; none for a trapped instruction.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1 → states 0,1,2,4,0. alu_op=0, alu_b_sel=0 in EXEC. rf_we=1, wb_sel=0, pc_we=1 in WB.
- LW with 2 wait cycles in fetch and 1 in MEM → FETCH lasts 3 cycles with mem_req held. MEM lasts 2 cycles with mem_we=0. WB has wb_sel=1. Total 8 cycles.
- BNE with zero=1, then zero=0 → not taken: pc_sel=0. Taken: pc_sel=1. pc_we=1 in EXEC both times; no rf_we.
- JALR → EXEC drives rf_we=1, wb_sel=2, pc_sel=2, alu_op=0, alu_b_sel=1 in the same cycle.
- Illegal opcode 0x7F, then SUB-form funct7=0100000 with funct3=001 → TRAP after DECODE, illegal=1, no pc_we/rf_we/mem_req until rst.
- Assert rst for 1 cycle during MEM of a store (mem_ready=0) → next state FETCH, no mem_we write completes, illegal=0.
